// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Definitions shared by the PWM duty generator and the PWM duty meter.
//   PWM_CNT_W is the common counter width, so the meter resolves duty to the
//   same granularity the generator produces.
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int PWM_CNT_W = 8;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,  // waiting for the first rising edge after reset
    RUN     = 2'd1,  // measuring between consecutive rising edges
    STUCK   = 2'd2   // no rising edge within counter range
  } pwm_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// -----------------------------------------------------------------------------
// pwm_edge_sync
//   Brings the asynchronous PWM pin into the clk domain and detects rising
//   edges of the synchronized level.
//
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   pwm_in  in   asynchronous PWM waveform
//   s       out  synchronized PWM level (last flop of the sync chain)
//   rise    out  single-cycle pulse: s is 1 now and was 0 one cycle ago
// -----------------------------------------------------------------------------
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic s,
  output logic rise
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("pwm_edge_sync: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s_d_q;
  logic                   s_d_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
    s_d_d  = sync_q[SYNC_STAGES-1];
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  // NOTE: asynchronous reset clears the chain without needing a clock, so a
  // stale high level cannot fake a rising edge right after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s_d_q  <= s_d_d;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// -----------------------------------------------------------------------------
// pwm_duty_meter
//   Measures period and high time (in clk cycles) of a PWM waveform, one
//   measurement per PWM period, and flags a line that stops toggling.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   pwm_in       in   asynchronous PWM waveform
//   period_cnt   out  cycles between the last two rising edges
//   high_cnt     out  cycles the line was high within that period
//   meas_valid   out  one-cycle strobe when period_cnt/high_cnt update
//   stuck        out  no rising edge seen within counter range
//   stuck_level  out  synchronized level captured when stuck was set
// -----------------------------------------------------------------------------
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int CNT_W       = PWM_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic s;
  logic rise;

  pwm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm_in(pwm_in),
    .s     (s),
    .rise  (rise)
  );

  pwm_state_e       state_q,       state_d;
  logic [CNT_W-1:0] per_acc_q,     per_acc_d;
  logic [CNT_W-1:0] hi_acc_q,      hi_acc_d;
  logic [CNT_W-1:0] period_cnt_q,  period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q,    high_cnt_d;
  logic             meas_valid_q,  meas_valid_d;
  logic             stuck_q,       stuck_d;
  logic             stuck_level_q, stuck_level_d;

  // The rise cycle is cycle 1 of the new period and is high, hence both
  // accumulators restart at 1. Incrementing only below CNT_MAX gives the
  // saturation; reaching CNT_MAX without a rise is what declares STUCK.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    per_acc_d     = per_acc_q;
    hi_acc_d      = hi_acc_q;
    period_cnt_d  = period_cnt_q;
    high_cnt_d    = high_cnt_q;
    meas_valid_d  = 1'b0;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;

    unique case (state_q)
      ACQUIRE: begin
        if (rise) begin
          per_acc_d = CNT_ONE;
          hi_acc_d  = CNT_ONE;
          state_d   = RUN;
        end else if (per_acc_q == CNT_MAX) begin
          state_d       = STUCK;
          stuck_d       = 1'b1;
          stuck_level_d = s;
        end else begin
          per_acc_d = per_acc_q + CNT_ONE;
        end
      end

      RUN: begin
        if (rise) begin
          // Publish the accumulators as they stood before this cycle.
          period_cnt_d = per_acc_q;
          high_cnt_d   = hi_acc_q;
          meas_valid_d = 1'b1;
          per_acc_d    = CNT_ONE;
          hi_acc_d     = CNT_ONE;
        end else if (per_acc_q == CNT_MAX) begin
          state_d       = STUCK;
          stuck_d       = 1'b1;
          stuck_level_d = s;
        end else begin
          per_acc_d = per_acc_q + CNT_ONE;
          if (s && (hi_acc_q != CNT_MAX)) begin
            hi_acc_d = hi_acc_q + CNT_ONE;
          end
        end
      end

      STUCK: begin
        // Recovery only re-arms the accumulators; the first measurement
        // after recovery needs a full period and arrives at the next rise.
        if (rise) begin
          stuck_d   = 1'b0;
          per_acc_d = CNT_ONE;
          hi_acc_d  = CNT_ONE;
          state_d   = RUN;
        end
      end

      default: begin
        state_d = ACQUIRE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ACQUIRE;
      per_acc_q     <= '0;
      hi_acc_q      <= '0;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      meas_valid_q  <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      per_acc_q     <= per_acc_d;
      hi_acc_q      <= hi_acc_d;
      period_cnt_q  <= period_cnt_d;
      high_cnt_q    <= high_cnt_d;
      meas_valid_q  <= meas_valid_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign period_cnt  = period_cnt_q;
  assign high_cnt    = high_cnt_q;
  assign meas_valid  = meas_valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_meter
//   Directed bench for pwm_duty_meter. pwm_in is driven and outputs are
//   sampled on the falling clock edge; a monitor logs every measurement with
//   its cycle stamp and counts rising edges of stuck.
// -----------------------------------------------------------------------------
module tb_pwm_duty_meter;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;

  logic             clk;
  logic             rst_n;
  logic             pwm_in;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;

  pwm_duty_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .meas_valid (meas_valid),
    .stuck      (stuck),
    .stuck_level(stuck_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp: number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sole writer of the measurement log and stuck counter.
  logic [15:0] meas_q[$];
  int          meas_cyc_q[$];
  int          stuck_rises = 0;
  logic        stuck_seen  = 1'b0;

  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      meas_q.push_back({period_cnt, high_cnt});
      meas_cyc_q.push_back(cyc);
    end
    if (stuck === 1'b1 && stuck_seen === 1'b0) stuck_rises = stuck_rises + 1;
    stuck_seen = stuck;
  end

  int n_pass   = 0;
  int n_checks = 0;
  int last_rise_cyc = 0;
  int base;
  int stuck_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_checks++;
    assert (obs === expd) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expd);
    end
  endtask

  // Checks one logged measurement; a missing entry reads as X and fails.
  task automatic check_entry(input string tag, input int idx, input int per, input int hi);
    logic [15:0] e;
    e = (idx < meas_q.size()) ? meas_q[idx] : 16'hxxxx;
    check({tag, "_period"}, 32'(e[15:8]), per);
    check({tag, "_high"},   32'(e[7:0]),  hi);
  endtask

  // Drives nper periods of the given shape, each starting with its high part.
  task automatic run_pwm(input int period, input int high, input int nper);
    for (int p = 0; p < nper; p++) begin
      for (int k = 0; k < period; k++) begin
        @(negedge clk);
        if (k == 0 && pwm_in == 1'b0 && high > 0) last_rise_cyc = cyc;
        pwm_in = (k < high);
      end
    end
  endtask

  task automatic hold(input int n, input logic level);
    repeat (n) begin
      @(negedge clk);
      pwm_in = level;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;

    // Reset state, before any clock edge.
    #2;
    check("rst_period_cnt",  32'(period_cnt),  0);
    check("rst_high_cnt",    32'(high_cnt),    0);
    check("rst_meas_valid",  32'(meas_valid),  0);
    check("rst_stuck",       32'(stuck),       0);
    check("rst_stuck_level", 32'(stuck_level), 0);

    hold(2, 1'b0);
    rst_n = 1'b1;

    // Line held low from reset: the idle timer hits 255 after 255 edges, the
    // STUCK transition lands on edge 256.
    hold(250, 1'b0);
    check("idle_not_yet_stuck", 32'(stuck), 0);
    hold(10, 1'b0);
    check("idle_stuck",       32'(stuck),       1);
    check("idle_stuck_level", 32'(stuck_level), 0);
    check("idle_no_meas",     32'(meas_q.size()), 0);

    // 10/3 for 6 periods: the first rise only recovers, rises 2..6 each
    // report 10/3 (5 measurements), 10 cycles apart, 3 cycles after the rise.
    base = meas_q.size();
    run_pwm(10, 3, 6);
    check("a_count", 32'(meas_q.size() - base), 5);
    for (int i = 0; i < 5; i++) check_entry($sformatf("a_meas%0d", i), base + i, 10, 3);
    for (int i = base; i + 1 < meas_cyc_q.size(); i++)
      check($sformatf("a_gap%0d", i - base), 32'(meas_cyc_q[i+1] - meas_cyc_q[i]), 10);
    check("a_latency", 32'(meas_cyc_q[meas_cyc_q.size()-1] - last_rise_cyc), SYNC_STAGES + 1);
    check("a_stuck", 32'(stuck), 0);

    // Duty change 3 -> 7 at a period boundary: the old period reports 10/3,
    // then 10/7 twice with nothing in between.
    base = meas_q.size();
    run_pwm(10, 7, 3);
    check("b_count", 32'(meas_q.size() - base), 3);
    check_entry("b_meas0", base,     10, 3);
    check_entry("b_meas1", base + 1, 10, 7);
    check_entry("b_meas2", base + 2, 10, 7);

    // One 10/3 period, then hold high: reports 10/7 (end of last 7-high
    // period) and 10/3, then goes stuck high about 258 edges after the rise.
    base = meas_q.size();
    run_pwm(10, 3, 1);
    hold(240, 1'b1);
    check("c_not_yet_stuck", 32'(stuck), 0);
    hold(60, 1'b1);
    check("c_stuck",       32'(stuck),       1);
    check("c_stuck_level", 32'(stuck_level), 1);
    check("c_period_held", 32'(period_cnt),  10);
    check("c_high_held",   32'(high_cnt),    3);
    check("c_count", 32'(meas_q.size() - base), 2);
    check_entry("c_meas0", base,     10, 7);
    check_entry("c_meas1", base + 1, 10, 3);

    // Resume at 5/20: stuck clears at the first rise without a measurement;
    // the next two rises report 20/5.
    hold(15, 1'b0);
    base = meas_q.size();
    run_pwm(20, 5, 1);
    check("r_stuck_cleared", 32'(stuck), 0);
    check("r_no_meas_yet",   32'(meas_q.size() - base), 0);
    run_pwm(20, 5, 2);
    check("r_count", 32'(meas_q.size() - base), 2);
    check_entry("r_meas0", base,     20, 5);
    check_entry("r_meas1", base + 1, 20, 5);

    // Period 300 / high 100: the first rise closes the last 20/5 period; after
    // that the counter saturates every period, so stuck sets three times and
    // nothing else is published.
    base       = meas_q.size();
    stuck_base = stuck_rises;
    run_pwm(300, 100, 3);
    check("d_count", 32'(meas_q.size() - base), 1);
    check_entry("d_meas0", base, 20, 5);
    check("d_stuck_rises", 32'(stuck_rises - stuck_base), 3);
    check("d_stuck",       32'(stuck),       1);
    check("d_stuck_level", 32'(stuck_level), 0);
    check("d_period_held", 32'(period_cnt),  20);
    check("d_high_held",   32'(high_cnt),    5);

    // Back to 10/3, then reset asynchronously mid-period.
    run_pwm(10, 3, 3);
    check("e_pre_period", 32'(period_cnt), 10);
    check("e_pre_high",   32'(high_cnt),   3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("e_rst_period_cnt",  32'(period_cnt),  0);
    check("e_rst_high_cnt",    32'(high_cnt),    0);
    check("e_rst_meas_valid",  32'(meas_valid),  0);
    check("e_rst_stuck",       32'(stuck),       0);
    check("e_rst_stuck_level", 32'(stuck_level), 0);
    hold(2, 1'b0);
    rst_n = 1'b1;
    base = meas_q.size();
    run_pwm(10, 3, 1);
    check("e_first_rise_no_meas", 32'(meas_q.size() - base), 0);
    run_pwm(10, 3, 1);
    check("e_count", 32'(meas_q.size() - base), 1);
    check_entry("e_meas0", base, 10, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
- Receive-side counterpart of the PWM duty generator: takes a PWM waveform on one pin and measures its period and high time in clk cycles.
- Publishes one measurement per PWM period, with a one-cycle valid strobe.
- Flags a stuck line (0% or 100% duty, or period beyond counter range) and reports the stuck level.
- Sits behind the io_in pin mapping, beside the generator, for loopback self-test of the duty controls.

Parameters:
- CNT_W, 8, width of period/high counters; maximum measurable period is 2^CNT_W-1 cycles.
- SYNC_STAGES, 2, number of metastability flops on pwm_in (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pwm_in  input  1  asynchronous PWM waveform under measurement.
- period_cnt  output  CNT_W  cycles between the last two rising edges.
- high_cnt  output  CNT_W  cycles pwm was high within that period.
- meas_valid  output  1  one-cycle strobe when period_cnt/high_cnt update.
- stuck  output  1  no rising edge seen for 2^CNT_W-1 cycles.
- stuck_level  output  1  synchronized pwm level when stuck was set.

Behaviour:
- Reset (async, rst_n=0): every output is 0, sync chain is 0, accumulators are 0, state is ACQUIRE.
- Sync: pwm_in passes through SYNC_STAGES flops to give s; s_d is s delayed by 1 cycle; rise = s & ~s_d.
- Latency: if pwm_in rises before clk edge 1, meas_valid is high after edge SYNC_STAGES+1 (edge 3 by default).
- Accumulators: per_acc and hi_acc, both CNT_W wide. Each saturates at all-ones and never wraps.
- ACQUIRE (waiting for the first edge):
  - per_acc counts as an idle timer; meas_valid is never raised in this state.
  - On rise: per_acc=1, hi_acc=1, go to RUN.
  - If per_acc reaches all-ones with no rise: go to STUCK.
- RUN (measuring):
  - Each cycle without rise: per_acc+=1; hi_acc+=1 when s=1.
  - On rise: period_cnt<=per_acc and high_cnt<=hi_acc (values before this cycle's increment); meas_valid<=1 for exactly that cycle; then per_acc=1, hi_acc=1.
  - The rise cycle itself counts as cycle 1 of the new period, high.
  - If per_acc reaches all-ones with no rise: go to STUCK, set stuck=1, set stuck_level=s. No meas_valid.
- STUCK:
  - period_cnt and high_cnt hold their last values.
  - On rise: stuck=0, per_acc=1, hi_acc=1, go to RUN. The first post-recovery measurement arrives at the next rise.
- Bounds: in valid measurements, 1 <= high_cnt <= period_cnt-1 and period_cnt >= 2.
- Glitches: a pulse shorter than 1 clk may be missed. That is accepted behaviour.
- Reset mid-period: the partial period is discarded; outputs go to 0.
- meas_valid is never asserted in the same cycle as the transition into STUCK.

Decomposition:
- Shared package pwm_pkg holds:
  - state enum {ACQUIRE, RUN, STUCK};
  - default CNT_W=8, shared with the generator so duty resolution matches.
- One sub-module, pwm_edge_sync: the SYNC_STAGES flop chain plus s_d register. Outputs s and rise; uses async active-low reset.

Test Plan:
- Reset then pwm period 10, high 3, for 5 periods -> after the 2nd rise, meas_valid pulses every 10 cycles with period_cnt=10, high_cnt=3, stuck=0.
- Change duty from high 3 to high 7 (period 10) mid-run -> the next full period reports high_cnt=7, period_cnt=10, with no spurious intermediate value.
- pwm_in held 0 after reset -> stuck=1 after 255 cycles (plus sync latency), stuck_level=0, meas_valid never asserted.
- Measure once at 3/10, then hold pwm_in at 1 -> stuck=1, stuck_level=1, period_cnt=10 and high_cnt=3 held. Resume 5/20 -> stuck clears at first rise; next valid reports 20/5.
- Period 300 (high 100) -> stuck asserted each period, meas_valid never asserted, no counter wrap.
- Assert rst_n=0 asynchronously mid-period while in RUN -> all outputs 0 immediately, before any clk edge. After release, the first measurement needs two rises.
